// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target receiver and the bus controller.
package i2c_pkg;

  localparam int I2C_ADDR_W  = 7;
  localparam int I2C_BYTE_W  = 8;
  localparam int FRAME_BYTES = 3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ACK_A     = 3'd2;
  localparam logic [2:0] ST_BYTE1     = 3'd3;
  localparam logic [2:0] ST_ACK_1     = 3'd4;
  localparam logic [2:0] ST_BYTE2     = 3'd5;
  localparam logic [2:0] ST_ACK_2     = 3'd6;
  localparam logic [2:0] ST_NACK_WAIT = 3'd7;

  // Byte 0 of a write frame: 7-bit address followed by R/W=0.
  function automatic logic [I2C_BYTE_W-1:0] write_addr_byte(input logic [I2C_ADDR_W-1:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into clk and flags bus events on the synchronised samples.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic start,
  output logic stop,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_h;
  logic                   sda_h;

  // Synchroniser chains plus history flops; reset to 1 (idle bus) so no false event follows reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_h    <= scl_s;
      sda_h    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign start = scl_s & scl_h & sda_h & ~sda_s;
  assign stop  = scl_s & scl_h & ~sda_h & sda_s;
  assign rise  = scl_s & ~scl_h;
  assign fall  = ~scl_s & scl_h;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: accepts {addr, byte1, byte2} and strobes {byte1, byte2} out.
//
// state        | meaning
// IDLE         | bus idle, waiting for START
// ADDR         | shifting in address byte
// ACK_A        | driving ACK for matching address
// BYTE1        | shifting in first data byte
// ACK_1        | driving ACK for first data byte
// BYTE2        | shifting in second data byte
// ACK_2        | driving ACK for second data byte, word emitted at its end
// NACK_WAIT    | SDA released, ignore bus until STOP or repeated START
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h1A,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic        word_valid,
  output logic [15:0] word_data,
  output logic        busy
);

  logic                  sda_s;
  logic                  ev_start;
  logic                  ev_stop;
  logic                  ev_rise;
  logic                  ev_fall;
  logic [2:0]            state;
  logic [2:0]            bit_cnt;
  logic [I2C_BYTE_W-1:0] shift_reg;
  logic [I2C_BYTE_W-1:0] byte1;
  logic                  phase_done;
  logic                  sda_low;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .scl     (i2c_sclk),
    .sda     (i2c_sdat),
    .sda_s   (sda_s),
    .start   (ev_start),
    .stop    (ev_stop),
    .rise    (ev_rise),
    .fall    (ev_fall)
  );

  assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

  // Frame FSM; phase_done marks that the next SCL fall closes the current byte or ACK slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shift_reg  <= '0;
      byte1      <= '0;
      phase_done <= 1'b0;
      sda_low    <= 1'b0;
      busy       <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= 16'h0000;
    end else begin
      word_valid <= 1'b0;
      if (ev_stop) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        sda_low    <= 1'b0;
        bit_cnt    <= 3'd0;
        phase_done <= 1'b0;
      end else if (ev_start) begin
        state      <= ST_ADDR;
        busy       <= 1'b1;
        sda_low    <= 1'b0;
        bit_cnt    <= 3'd0;
        phase_done <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_BYTE1, ST_BYTE2: begin
            if (ev_rise) begin
              shift_reg <= {shift_reg[I2C_BYTE_W-2:0], sda_s};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) phase_done <= 1'b1;
            end else if (ev_fall && phase_done) begin
              phase_done <= 1'b0;
              if (state == ST_ADDR) begin
                if (shift_reg == write_addr_byte(DEV_ADDR)) begin
                  sda_low <= 1'b1;
                  state   <= ST_ACK_A;
                end else begin
                  state   <= ST_NACK_WAIT;
                end
              end else if (state == ST_BYTE1) begin
                byte1   <= shift_reg;
                sda_low <= 1'b1;
                state   <= ST_ACK_1;
              end else begin
                sda_low <= 1'b1;
                state   <= ST_ACK_2;
              end
            end
          end
          ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
            if (ev_rise) begin
              phase_done <= 1'b1;
            end else if (ev_fall && phase_done) begin
              phase_done <= 1'b0;
              sda_low    <= 1'b0;
              if (state == ST_ACK_A) begin
                state <= ST_BYTE1;
              end else if (state == ST_ACK_1) begin
                state <= ST_BYTE2;
              end else begin
                word_data  <= {byte1, shift_reg};
                word_valid <= 1'b1;
                state      <= ST_NACK_WAIT;
              end
            end
          end
          default: begin
            sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged controller on a pulled-up SDA line.
module tb_i2c_target_rx;

  logic        clk;
  logic        reset_n;
  logic        scl;
  logic        ctl_low;
  tri1         sda_bus;
  logic        word_valid;
  logic [15:0] word_data;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_cyc = 0;
  int last_lat = 0;
  int wv_cnt   = 0;
  logic drove  = 1'b0;

  assign sda_bus = ctl_low ? 1'b0 : 1'bz;

  i2c_target_rx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i2c_sclk   (scl),
    .i2c_sdat   (sda_bus),
    .word_valid (word_valid),
    .word_data  (word_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: counts word strobes, their latency, and any SDA low not caused by the controller.
  always @(negedge clk) begin
    if (word_valid === 1'b1) begin
      wv_cnt   <= wv_cnt + 1;
      last_lat <= cyc - fall_cyc;
    end
    if (sda_bus === 1'b0 && !ctl_low) drove <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (5) @(negedge clk);
  endtask

  task automatic bus_start();
    ctl_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    ctl_low = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic bus_stop();
    ctl_low = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    ctl_low = 1'b0;
    wait_q();
  endtask

  task automatic send_bit(input logic b);
    ctl_low = ~b;
    wait_q();
    scl = 1'b1;
    wait_q();
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ack_bit(output logic ack);
    ctl_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    ack = (sda_bus === 1'b0);
    wait_q();
    scl = 1'b0;
    fall_cyc = cyc;
    wait_q();
  endtask

  task automatic send_frame(input logic [23:0] f, output logic [2:0] acks);
    logic a;
    bus_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      send_byte(f[23-8*i -: 8]);
      ack_bit(a);
      acks[2-i] = a;
    end
    bus_stop();
  endtask

  typedef struct {
    logic [23:0] frame;
    logic [2:0]  exp_ack;
    int          exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [2:0] acks;
    logic       a;
    int         wv0;

    vecs[0] = '{24'h34_1E_00, 3'b111, 1, 16'h1E00};
    vecs[1] = '{24'h36_12_34, 3'b000, 0, 16'h1E00};
    vecs[2] = '{24'h35_12_34, 3'b000, 0, 16'h1E00};
    vecs[3] = '{24'h34_FF_FF, 3'b111, 1, 16'hFFFF};
    vecs[4] = '{24'h34_00_01, 3'b111, 1, 16'h0001};

    reset_n = 1'b0;
    scl     = 1'b1;
    ctl_low = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_word_valid", {31'd0, word_valid}, 32'd0);
    check("rst_word_data", {16'd0, word_data}, 32'h0000);
    check("rst_sda_released", {31'd0, sda_bus}, 32'd1);
    reset_n = 1'b1;
    wait_q();

    for (int v = 0; v < 5; v++) begin
      wv0   = wv_cnt;
      drove = 1'b0;
      send_frame(vecs[v].frame, acks);
      wait_q();
      check($sformatf("v%0d_acks", v), {29'd0, acks}, {29'd0, vecs[v].exp_ack});
      check($sformatf("v%0d_valid_cnt", v), wv_cnt - wv0, vecs[v].exp_valid);
      check($sformatf("v%0d_word_data", v), {16'd0, word_data}, {16'd0, vecs[v].exp_data});
      check($sformatf("v%0d_busy_after_stop", v), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_sda_driven", v), {31'd0, drove}, {31'd0, vecs[v].exp_ack != 3'b000});
      if (vecs[v].exp_valid == 1)
        check($sformatf("v%0d_latency", v), last_lat, 32'd3);
    end

    // STOP in the middle of byte 2 discards the partial frame.
    wv0 = wv_cnt;
    bus_start();
    send_byte(8'h34);
    ack_bit(a);
    check("abort_ack_addr", {31'd0, a}, 32'd1);
    send_byte(8'h99);
    ack_bit(a);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_stop();
    wait_q();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_valid", wv_cnt - wv0, 32'd0);
    check("abort_data_kept", {16'd0, word_data}, 32'h0001);
    send_frame(24'h34_0C_5A, acks);
    wait_q();
    check("after_abort_acks", {29'd0, acks}, 32'd7);
    check("after_abort_valid", wv_cnt - wv0, 32'd1);
    check("after_abort_data", {16'd0, word_data}, 32'h0C5A);

    // Repeated START after byte 1 restarts the frame.
    wv0 = wv_cnt;
    bus_start();
    send_byte(8'h34);
    ack_bit(a);
    send_byte(8'h77);
    ack_bit(a);
    check("rs_ack_byte1", {31'd0, a}, 32'd1);
    send_frame(24'h34_AB_CD, acks);
    wait_q();
    check("rs_acks", {29'd0, acks}, 32'd7);
    check("rs_valid_cnt", wv_cnt - wv0, 32'd1);
    check("rs_data", {16'd0, word_data}, 32'hABCD);

    // Reset asserted while the target is acking byte 1.
    wv0 = wv_cnt;
    bus_start();
    send_byte(8'h34);
    ack_bit(a);
    send_byte(8'h55);
    ctl_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    check("rstack_sda_low", {31'd0, sda_bus === 1'b0}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rstack_sda_released", {31'd0, sda_bus === 1'b1}, 32'd1);
    check("rstack_busy", {31'd0, busy}, 32'd0);
    check("rstack_word_valid", {31'd0, word_valid}, 32'd0);
    check("rstack_word_data", {16'd0, word_data}, 32'h0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
    bus_stop();
    send_frame(24'h34_5A_A5, acks);
    wait_q();
    check("rstack_next_acks", {29'd0, acks}, 32'd7);
    check("rstack_next_valid", wv_cnt - wv0, 32'd1);
    check("rstack_next_data", {16'd0, word_data}, 32'h5AA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
